// File: rtl/ysyx_210544_id_fifo_pkg.sv
// rtl/ysyx_210544_id_fifo_pkg.sv - shared widths and record layout for the fetch/decode buffer
package ysyx_210544_id_fifo_pkg;

    localparam int BUS_64 = 64;
    localparam int BUS_32 = 32;

    // Record field order, MSB first: {nocmt, inst, pc}
    typedef struct packed {
        logic              nocmt;
        logic [BUS_32-1:0] inst;
        logic [BUS_64-1:0] pc;
    } id_rec_t;

    function automatic int rec_width(input int pc_w, input int inst_w);
        return pc_w + inst_w + 1;
    endfunction

endpackage

// File: rtl/ysyx_210544_id_fifo_mem.sv
// rtl/ysyx_210544_id_fifo_mem.sv - DEPTH x WIDTH register array, sync write, async read
module ysyx_210544_id_fifo_mem #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 97,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ysyx_210544_id_fifo.sv
// rtl/ysyx_210544_id_fifo.sv - fetch-to-decode record FIFO with flush and occupancy count
module ysyx_210544_id_fifo
    import ysyx_210544_id_fifo_pkg::*;
#(
    parameter int PC_W    = BUS_64,
    parameter int INST_W  = BUS_32,
    parameter int DEPTH   = 4,
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_flush,
    input  logic              i_fetched_req,
    output logic              o_fetched_ack,
    input  logic [PC_W-1:0]   i_pc,
    input  logic [INST_W-1:0] i_inst,
    input  logic              i_nocmt,
    output logic              o_decoded_req,
    input  logic              i_decoded_ack,
    output logic [PC_W-1:0]   o_pc,
    output logic [INST_W-1:0] o_inst,
    output logic              o_nocmt,
    output logic [CNT_W-1:0]  o_count
);

    localparam int AW    = $clog2(DEPTH);
    localparam int REC_W = rec_width(PC_W, INST_W);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full, empty, push, pop;
    logic [REC_W-1:0] wdata, rdata;

    // Full/empty come only from the registered count, so a pop never frees a slot in the same cycle
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign push  = i_fetched_req & ~full;
    assign pop   = i_decoded_ack & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (pop && !push) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign wdata = {i_nocmt, i_inst, i_pc};

    ysyx_210544_id_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (REC_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (push & ~i_flush),
        .waddr_i (wr_ptr_q),
        .wdata_i (wdata),
        .raddr_i (rd_ptr_q),
        .rdata_o (rdata)
    );

    // Empty gating hides uninitialised storage from the decoder
    assign o_fetched_ack = ~full;
    assign o_decoded_req = ~empty;
    assign o_pc          = empty ? '0 : rdata[PC_W-1:0];
    assign o_inst        = empty ? '0 : rdata[PC_W+INST_W-1:PC_W];
    assign o_nocmt       = empty ? 1'b0 : rdata[REC_W-1];
    assign o_count       = count_q;

endmodule

// File: tb/tb_ysyx_210544_id_fifo.sv
// tb/tb_ysyx_210544_id_fifo.sv - directed vector bench for ysyx_210544_id_fifo
module tb_ysyx_210544_id_fifo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_flush, i_fetched_req, i_nocmt, i_decoded_ack;
    logic [63:0] i_pc;
    logic [31:0] i_inst;
    logic        o_fetched_ack, o_decoded_req, o_nocmt;
    logic [63:0] o_pc;
    logic [31:0] o_inst;
    logic [2:0]  o_count;

    int pass_cnt = 0;
    int total    = 0;

    typedef struct {
        logic        flush, req;
        logic [63:0] pc;
        logic [31:0] inst;
        logic        nocmt, ack;
        logic        e_req, e_fack;
        logic [2:0]  e_cnt;
        logic [63:0] e_pc;
        logic [31:0] e_inst;
        logic        e_nocmt;
    } vec_t;

    vec_t vecs [28];

    ysyx_210544_id_fifo #(.PC_W(64), .INST_W(32), .DEPTH(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_flush       (i_flush),
        .i_fetched_req (i_fetched_req),
        .o_fetched_ack (o_fetched_ack),
        .i_pc          (i_pc),
        .i_inst        (i_inst),
        .i_nocmt       (i_nocmt),
        .o_decoded_req (o_decoded_req),
        .i_decoded_ack (i_decoded_ack),
        .o_pc          (o_pc),
        .o_inst        (o_inst),
        .o_nocmt       (o_nocmt),
        .o_count       (o_count)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic f, input logic r, input logic [63:0] pc, input logic [31:0] inst,
                                input logic nc, input logic a, input logic er, input logic efa,
                                input logic [2:0] ec, input logic [63:0] epc, input logic [31:0] einst, input logic enc);
        vec_t v;
        v.flush = f; v.req = r; v.pc = pc; v.inst = inst; v.nocmt = nc; v.ack = a;
        v.e_req = er; v.e_fack = efa; v.e_cnt = ec; v.e_pc = epc; v.e_inst = einst; v.e_nocmt = enc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic chk_all(input string tag, input logic er, input logic efa, input logic [2:0] ec,
                           input logic [63:0] epc, input logic [31:0] einst, input logic enc);
        chk({tag, ".req"},   64'(o_decoded_req), 64'(er));
        chk({tag, ".ack"},   64'(o_fetched_ack), 64'(efa));
        chk({tag, ".count"}, 64'(o_count),       64'(ec));
        chk({tag, ".pc"},    o_pc,               epc);
        chk({tag, ".inst"},  64'(o_inst),        64'(einst));
        chk({tag, ".nocmt"}, 64'(o_nocmt),       64'(enc));
    endtask

    task automatic step(input logic f, input logic r, input logic [63:0] pc, input logic [31:0] inst,
                        input logic nc, input logic a);
        i_flush = f; i_fetched_req = r; i_pc = pc; i_inst = inst; i_nocmt = nc; i_decoded_ack = a;
        @(posedge clk);
        #1;
        i_flush = 0; i_fetched_req = 0; i_decoded_ack = 0;
    endtask

    initial begin
        // idle, single push/pop
        vecs[0]  = mk(0,0,64'h0,64'h0,0,0,            0,1,3'd0,64'h0,32'h0,0);
        vecs[1]  = mk(0,1,64'h80000000,32'h00100093,0,0, 1,1,3'd1,64'h80000000,32'h00100093,0);
        vecs[2]  = mk(0,0,64'h0,32'h0,0,1,            0,1,3'd0,64'h0,32'h0,0);
        // fill past capacity
        vecs[3]  = mk(0,1,64'h1000,32'h10000013,0,0,  1,1,3'd1,64'h1000,32'h10000013,0);
        vecs[4]  = mk(0,1,64'h1004,32'h10040013,1,0,  1,1,3'd2,64'h1000,32'h10000013,0);
        vecs[5]  = mk(0,1,64'h1008,32'h10080013,0,0,  1,1,3'd3,64'h1000,32'h10000013,0);
        vecs[6]  = mk(0,1,64'h100C,32'h100C0013,0,0,  1,0,3'd4,64'h1000,32'h10000013,0);
        vecs[7]  = mk(0,1,64'h1010,32'h10100013,0,0,  1,0,3'd4,64'h1000,32'h10000013,0);
        vecs[8]  = mk(0,0,64'h0,32'h0,0,1,            1,1,3'd3,64'h1004,32'h10040013,1);
        vecs[9]  = mk(0,0,64'h0,32'h0,0,1,            1,1,3'd2,64'h1008,32'h10080013,0);
        vecs[10] = mk(0,0,64'h0,32'h0,0,1,            1,1,3'd1,64'h100C,32'h100C0013,0);
        vecs[11] = mk(0,0,64'h0,32'h0,0,1,            0,1,3'd0,64'h0,32'h0,0);
        // full with simultaneous push and pop
        vecs[12] = mk(0,1,64'h4000,32'h40000013,0,0,  1,1,3'd1,64'h4000,32'h40000013,0);
        vecs[13] = mk(0,1,64'h4004,32'h40040013,0,0,  1,1,3'd2,64'h4000,32'h40000013,0);
        vecs[14] = mk(0,1,64'h4008,32'h40080013,0,0,  1,1,3'd3,64'h4000,32'h40000013,0);
        vecs[15] = mk(0,1,64'h400C,32'h400C0013,0,0,  1,0,3'd4,64'h4000,32'h40000013,0);
        vecs[16] = mk(0,1,64'h4010,32'h40100013,0,1,  1,1,3'd3,64'h4004,32'h40040013,0);
        vecs[17] = mk(0,1,64'h4010,32'h40100013,0,0,  1,0,3'd4,64'h4004,32'h40040013,0);
        vecs[18] = mk(0,0,64'h0,32'h0,0,1,            1,1,3'd3,64'h4008,32'h40080013,0);
        vecs[19] = mk(0,0,64'h0,32'h0,0,1,            1,1,3'd2,64'h400C,32'h400C0013,0);
        vecs[20] = mk(0,0,64'h0,32'h0,0,1,            1,1,3'd1,64'h4010,32'h40100013,0);
        vecs[21] = mk(0,0,64'h0,32'h0,0,1,            0,1,3'd0,64'h0,32'h0,0);
        // flush beats push and pop
        vecs[22] = mk(0,1,64'h5000,32'h50000013,0,0,  1,1,3'd1,64'h5000,32'h50000013,0);
        vecs[23] = mk(0,1,64'h5004,32'h50040013,0,0,  1,1,3'd2,64'h5000,32'h50000013,0);
        vecs[24] = mk(0,1,64'h5008,32'h50080013,0,0,  1,1,3'd3,64'h5000,32'h50000013,0);
        vecs[25] = mk(1,1,64'h2000,32'h20000013,1,1,  0,1,3'd0,64'h0,32'h0,0);
        vecs[26] = mk(0,1,64'h3000,32'h30000013,0,0,  1,1,3'd1,64'h3000,32'h30000013,0);
        vecs[27] = mk(0,0,64'h0,32'h0,0,1,            0,1,3'd0,64'h0,32'h0,0);

        rst_n = 0; i_flush = 0; i_fetched_req = 0; i_pc = '0; i_inst = '0; i_nocmt = 0; i_decoded_ack = 0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1;
        #1;
        chk_all("reset", 0, 1, 3'd0, 64'h0, 32'h0, 0);

        for (int i = 0; i < 28; i++) begin
            step(vecs[i].flush, vecs[i].req, vecs[i].pc, vecs[i].inst, vecs[i].nocmt, vecs[i].ack);
            chk_all($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_fack, vecs[i].e_cnt,
                    vecs[i].e_pc, vecs[i].e_inst, vecs[i].e_nocmt);
        end

        // streaming across pointer wrap: occupancy stays at one
        step(0, 1, 64'h6000, 32'h60000013, 0, 0);
        chk_all("stream0", 1, 1, 3'd1, 64'h6000, 32'h60000013, 0);
        for (int i = 1; i < 10; i++) begin
            step(0, 1, 64'h6000 + 64'(4 * i), 32'h60000013 + 32'(i << 16), 0, 1);
            chk_all($sformatf("stream%0d", i), 1, 1, 3'd1, 64'h6000 + 64'(4 * i),
                    32'h60000013 + 32'(i << 16), 0);
        end
        step(0, 0, 64'h0, 32'h0, 0, 1);
        chk_all("stream_end", 0, 1, 3'd0, 64'h0, 32'h0, 0);

        // asynchronous reset in the middle of a cycle
        step(0, 1, 64'h7000, 32'h70000013, 1, 0);
        step(0, 1, 64'h7004, 32'h70040013, 0, 0);
        chk_all("pre_rst", 1, 1, 3'd2, 64'h7000, 32'h70000013, 1);
        #2 rst_n = 0;
        #1;
        chk_all("async_rst", 0, 1, 3'd0, 64'h0, 32'h0, 0);
        @(negedge clk);
        rst_n = 1;
        step(0, 0, 64'h0, 32'h0, 0, 1);
        chk_all("post_rst", 0, 1, 3'd0, 64'h0, 32'h0, 0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
